// File: rtl/fetch_unit.sv
// fetch_unit: PC generator and in-order instruction fetch front end.
// Issues imem reads under a credit limit, buffers returned words for Decode and
// applies Execute redirects by retargeting the PC and squashing stale reads.
module fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter int                BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              global_disable,
  input  logic [ADDR_W-1:0] branch_pc,
  input  logic [31:0]       delta_instruction,
  output logic              dbg_state
);

  // Handshakes: a transfer happens on a posedge where valid && ready; valid never
  // depends on ready, and data/address are stable whenever valid is high.

  localparam int               CNT_W    = $clog2(BUF_DEPTH + 1);
  localparam int               PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(BUF_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_SQUASH = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  squash_q, squash_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  tag_rd_q, tag_rd_d, tag_wr_q, tag_wr_d;
  logic [31:0]       buf_data_q [BUF_DEPTH];
  logic [31:0]       buf_data_d [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_d   [BUF_DEPTH];
  logic [ADDR_W-1:0] tag_pc_q   [BUF_DEPTH];
  logic [ADDR_W-1:0] tag_pc_d   [BUF_DEPTH];

  logic              req_fire, rsp_ok, rsp_drop, rsp_keep, deq;
  logic [ADDR_W-1:0] offset, redirect_pc;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Offset counts instructions, so scale by 4 after sign extension.
  assign offset      = ADDR_W'({{30{delta_instruction[31]}}, delta_instruction, 2'b00});
  assign redirect_pc = branch_pc + offset;

  // Credit covers both in-flight reads and buffered words, so the buffer cannot overflow.
  assign imem_req_valid = !rst && !global_disable &&
                          (({1'b0, inflight_q} + {1'b0, count_q}) < DEPTH_W);
  assign imem_addr      = pc_q;
  assign instr_valid    = (count_q != '0);
  assign instr_data     = instr_valid ? buf_data_q[rd_ptr_q] : '0;
  assign instr_pc       = instr_valid ? buf_pc_q[rd_ptr_q] : '0;
  assign dbg_state      = (state_q == ST_SQUASH);

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_ok   = imem_rsp_valid && (inflight_q != '0);
  assign rsp_drop = rsp_ok && (state_q == ST_SQUASH);
  assign rsp_keep = rsp_ok && !rsp_drop && !global_disable;
  assign deq      = instr_valid && instr_ready;

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    tag_rd_d   = tag_rd_q;
    tag_wr_d   = tag_wr_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    tag_pc_d   = tag_pc_q;
    squash_d   = squash_q;
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_ok);
    count_d    = count_q + CNT_W'(rsp_keep) - CNT_W'(deq);

    if (req_fire) begin
      tag_pc_d[tag_wr_q] = pc_q;
      tag_wr_d           = ptr_inc(tag_wr_q);
      pc_d               = pc_q + ADDR_W'(4);
    end
    if (rsp_keep) begin
      buf_data_d[wr_ptr_q] = imem_rsp_data;
      buf_pc_d[wr_ptr_q]   = tag_pc_q[tag_rd_q];
      wr_ptr_d             = ptr_inc(wr_ptr_q);
      tag_rd_d             = ptr_inc(tag_rd_q);
    end
    if (deq) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (rsp_drop) begin
      squash_d = squash_q - CNT_W'(1);
    end

    // Every read still outstanding after this edge belongs to the old path.
    if (global_disable) begin
      pc_d     = redirect_pc;
      squash_d = inflight_d;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      tag_rd_d = '0;
      tag_wr_d = '0;
    end

    state_d = (squash_d != '0) ? ST_SQUASH : ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      count_q    <= '0;
      squash_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      tag_rd_q   <= '0;
      tag_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      squash_q   <= squash_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      tag_rd_q   <= tag_rd_d;
      tag_wr_q   <= tag_wr_d;
    end
    buf_data_q <= buf_data_d;
    buf_pc_q   <= buf_pc_d;
    tag_pc_q   <= tag_pc_d;
  end

  rsp_needs_inflight: assert property (@(posedge clk) disable iff (rst)
    !(imem_rsp_valid && (inflight_q == '0)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed fetch scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the fetch front end.
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
  logic        global_disable;
  logic [31:0] branch_pc, delta_instruction;
  logic        dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .global_disable(global_disable), .branch_pc(branch_pc),
    .delta_instruction(delta_instruction),
    .dbg_state(dbg_state)
  );

  // ---------------- model and scoreboard state ----------------
  typedef struct packed { logic [31:0] pc; logic sq; } infl_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  infl_t       m_infl[$];   // reads the DUT has outstanding, oldest first
  logic [63:0] exp_q[$];    // {data, pc} words Decode should see, head first
  logic [31:0] m_pc;
  mreq_t       mem_q[$];
  logic [31:0] pop_log[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   lat_min = 1, lat_max = 1, rdy_pct = 100;
  bit   rnd_mem = 1'b0;
  bit   chk_en = 1'b0;
  logic acc_now;
  logic [31:0] acc_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit model_req_valid();
    return !rst && !global_disable && ((m_infl.size() + exp_q.size()) < DEPTH);
  endfunction

  function automatic bit model_squashing();
    bit any = 1'b0;
    foreach (m_infl[i]) if (m_infl[i].sq) any = 1'b1;
    return any;
  endfunction

  task automatic compare();
    if (!chk_en) return;
    chk1("req_valid", imem_req_valid, model_req_valid());
    chk("imem_addr", imem_addr, m_pc);
    chk1("instr_valid", instr_valid, exp_q.size() > 0);
    chk1("squash_state", dbg_state, model_squashing());
    if (exp_q.size() > 0) begin
      chk("instr_data", instr_data, exp_q[0][63:32]);
      chk("instr_pc", instr_pc, exp_q[0][31:0]);
    end
    if (instr_valid && instr_ready && !rst) begin
      chk("data_vs_mem", instr_data, mem_word(instr_pc));
      pop_log.push_back(instr_pc);
    end
  endtask

  // Applies the inputs present at this edge to the transaction-level model.
  task automatic model_update();
    bit    acc;
    infl_t e;
    if (rst) begin
      m_pc = RST_PC;
      m_infl.delete();
      exp_q.delete();
      return;
    end
    acc = model_req_valid() && imem_req_ready;
    if (exp_q.size() > 0 && instr_ready) void'(exp_q.pop_front());
    if (imem_rsp_valid && m_infl.size() > 0) begin
      e = m_infl.pop_front();
      if (!e.sq && !global_disable) exp_q.push_back({imem_rsp_data, e.pc});
    end
    if (global_disable) begin
      foreach (m_infl[i]) m_infl[i].sq = 1'b1;
      exp_q.delete();
      m_pc = branch_pc + delta_instruction * 32'd4;
    end else if (acc) begin
      m_infl.push_back('{pc: m_pc, sq: 1'b0});
      m_pc = m_pc + 32'd4;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_mem();
    if (rst) begin
      mem_q.delete();
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      return;
    end
    imem_req_ready = ($urandom_range(1, 100) <= rdy_pct);
    if (mem_q.size() > 0 && mem_q[0].due <= cyc && (!rnd_mem || $urandom_range(0, 3) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic cycle();
    cyc++;
    drive_mem();
    #1;
    compare();
    acc_now  = imem_req_valid && imem_req_ready;
    acc_addr = imem_addr;
    @(posedge clk);
    model_update();
    if (imem_rsp_valid) void'(mem_q.pop_front());
    if (acc_now) mem_q.push_back('{addr: acc_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
    @(negedge clk);
  endtask

  task automatic restart(input int lat);
    lat_min = lat;
    lat_max = lat;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    pop_log.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] last_pc;
    rst = 1'b1; global_disable = 1'b0; branch_pc = '0; delta_instruction = '0;
    instr_ready = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    m_pc = RST_PC;
    @(negedge clk);
    cycle();
    chk_en = 1'b1;
    cycle();

    // Reset values
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk1("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);

    // 1: sequential fetch from RESET_PC, latency 1
    rst = 1'b0;
    pop_log.delete();
    #1;
    chk1("t1_first_req", imem_req_valid, 1'b1);
    chk("t1_first_addr", imem_addr, 32'h0);
    repeat (24) cycle();
    chk1("t1_enough_pops", pop_log.size() >= 8, 1'b1);
    for (int i = 0; i < 8; i++) chk("t1_order", pop_log[i], 32'(i * 4));

    // 2: Decode stalls, exactly DEPTH words held, then drained in order
    last_pc = pop_log[pop_log.size() - 1];
    instr_ready = 1'b0;
    repeat (10) cycle();
    #1;
    chk1("t2_req_stalled", imem_req_valid, 1'b0);
    instr_ready = 1'b1;
    pop_log.delete();
    chk1("t2_hold0", instr_valid, 1'b1);
    cycle();
    chk1("t2_hold1", instr_valid, 1'b1);
    cycle();
    chk1("t2_drained", instr_valid, 1'b0);
    repeat (20) cycle();
    chk("t2_resume_pc", pop_log[0], last_pc + 32'd4);
    for (int i = 1; i < pop_log.size(); i++) chk("t2_order", pop_log[i], pop_log[i-1] + 32'd4);

    // 3: redirect with two reads in flight
    restart(3);
    cycle();
    cycle();
    global_disable = 1'b1; branch_pc = 32'h100; delta_instruction = 32'hFFFF_FFFE;
    cycle();
    global_disable = 1'b0;
    chk("t3_target", imem_addr, 32'h0F8);
    chk1("t3_flushed", instr_valid, 1'b0);
    chk1("t3_squashing", dbg_state, 1'b1);
    repeat (20) cycle();
    chk("t3_first_pc", pop_log[0], 32'h0F8);
    chk("t3_second_pc", pop_log[1], 32'h0FC);

    // 4: redirect in the same cycle a response returns
    restart(2);
    cycle();
    cycle();
    global_disable = 1'b1; branch_pc = 32'h200; delta_instruction = 32'd3;
    cycle();
    global_disable = 1'b0;
    chk("t4_target", imem_addr, 32'h20C);
    chk1("t4_squashing", dbg_state, 1'b1);
    repeat (20) cycle();
    chk("t4_first_pc", pop_log[0], 32'h20C);
    chk("t4_second_pc", pop_log[1], 32'h210);

    // 5: address wrap and negative-offset wrap
    restart(1);
    global_disable = 1'b1; branch_pc = 32'hFFFF_FFF0; delta_instruction = 32'd3;
    cycle();
    global_disable = 1'b0;
    chk("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    cycle();
    chk("t5_wrap_addr", imem_addr, 32'h0);
    repeat (6) cycle();
    chk("t5_pop_top", pop_log[0], 32'hFFFF_FFFC);
    chk("t5_pop_zero", pop_log[1], 32'h0);
    global_disable = 1'b1; branch_pc = 32'h4; delta_instruction = 32'hFFFF_FFFC;
    cycle();
    global_disable = 1'b0;
    chk("t5_neg_target", imem_addr, 32'hFFFF_FFF4);

    // 6: reset with a buffered word and a read in flight
    restart(3);
    instr_ready = 1'b0;
    repeat (4) cycle();
    chk1("t6_buffered", instr_valid, 1'b1);
    rst = 1'b1;
    cycle();
    chk("t6_addr", imem_addr, RST_PC);
    chk1("t6_instr_valid", instr_valid, 1'b0);
    chk("t6_instr_data", instr_data, 32'h0);
    chk("t6_instr_pc", instr_pc, 32'h0);
    chk1("t6_state", dbg_state, 1'b0);
    #1;
    chk1("t6_req_in_rst", imem_req_valid, 1'b0);
    rst = 1'b0;
    instr_ready = 1'b1;
    pop_log.delete();
    #1;
    chk1("t6_restart_req", imem_req_valid, 1'b1);
    repeat (12) cycle();
    chk("t6_first_pc", pop_log[0], RST_PC);
    chk("t6_second_pc", pop_log[1], RST_PC + 32'd4);

    // Randomized traffic: memory stalls/latency, Decode stalls, redirects, resets
    rnd_mem = 1'b1;
    lat_min = 1;
    lat_max = 4;
    for (int seg = 0; seg < 3; seg++) begin
      rdy_pct = (seg == 0) ? 100 : (seg == 1) ? 60 : 30;
      for (int n = 0; n < 1000; n++) begin
        instr_ready       = ($urandom_range(0, 3) != 0);
        global_disable    = ($urandom_range(0, 24) == 0);
        branch_pc         = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        delta_instruction = 32'($urandom_range(0, 64)) - 32'd32;
        rst               = ($urandom_range(0, 499) == 0);
        cycle();
      end
    end
    rst = 1'b0;
    global_disable = 1'b0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
